// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM
// state encoding and requester port identifiers.
package dmem_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way winner select with a registered round-robin pointer; the pointer
// only moves when it was actually used to break a tie.
module rr_arb2
    import dmem_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic any_req,
    output logic win
);

    localparam bit FIXED = (FIXED_PRIO != 0);

    logic ptr_q;
    logic tie;

    assign tie     = req0 & req1;
    assign any_req = req0 | req1;

    always_comb begin
        win = PORT0;
        if (tie) begin
            win = FIXED ? PORT0 : ptr_q;
        end else if (req1) begin
            win = PORT1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PORT0;
        end else if (en && tie && !FIXED) begin
            ptr_q <= other_port(ptr_q);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single-port data memory:
// IDLE -> ISSUE -> RESP, one access every three cycles.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id
);

    state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              gnt_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              any_req;
    logic              win;
    logic              arb_en;

    assign arb_en = (state_q == IDLE);

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req0   (req0),
        .req1   (req1),
        .any_req(any_req),
        .win    (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and acks are gated by rst_n so an access caught by reset
    // never reaches the memory and is never acknowledged.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d   = RESP;
                mem_write = rst_n & we_q;
                mem_read  = rst_n & ~we_q;
            end
            RESP: begin
                state_d = IDLE;
                ack0    = rst_n & (gnt_q == PORT0);
                ack1    = rst_n & (gnt_q == PORT1);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt_q   <= PORT0;
        end else if (state_q == IDLE && any_req) begin
            gnt_q <= win;
            if (win == PORT1) begin
                we_q    <= we1;
                addr_q  <= addr1;
                wdata_q <= wdata1;
            end else begin
                we_q    <= we0;
                addr_q  <= addr0;
                wdata_q <= wdata0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (ack0 && !we_q) begin
                rdata0_q <= mem_rdata;
            end
            if (ack1 && !we_q) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    // Memory data only arrives in RESP, so the ack cycle forwards it
    // directly; the holding register covers every later cycle.
    assign rdata0    = (ack0 && !we_q) ? mem_rdata : rdata0_q;
    assign rdata1    = (ack1 && !we_q) ? mem_rdata : rdata1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives a round-robin (index 0) and a fixed-priority (index 1) arbiter,
// each with its own memory, against a transaction-order reference model.
module tb_dmem_arbiter;

    logic clk;
    logic [1:0] rst_n_v, req0_v, we0_v, req1_v, we1_v;
    logic [1:0] ack0_v, ack1_v, mem_read_v, mem_write_v, busy_v, gnt_v;
    logic [7:0] addr0_v [2];
    logic [7:0] wdata0_v [2];
    logic [7:0] addr1_v [2];
    logic [7:0] wdata1_v [2];
    logic [7:0] rdata0_v [2];
    logic [7:0] rdata1_v [2];
    logic [7:0] mem_addr_v [2];
    logic [7:0] mem_wdata_v [2];
    logic [7:0] mem_rdata_v [2] = '{default: 8'h00};
    logic [7:0] tmem [2][256] = '{default: '{default: 8'h00}};

    logic [7:0] ref_mem [2][256] = '{default: '{default: 8'h00}};
    logic [7:0] exp_rd [2][2];
    bit         rr_ptr [2];
    int         checks;
    int         errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst_n(rst_n_v[0]),
        .req0(req0_v[0]), .we0(we0_v[0]), .addr0(addr0_v[0]), .wdata0(wdata0_v[0]),
        .ack0(ack0_v[0]), .rdata0(rdata0_v[0]),
        .req1(req1_v[0]), .we1(we1_v[0]), .addr1(addr1_v[0]), .wdata1(wdata1_v[0]),
        .ack1(ack1_v[0]), .rdata1(rdata1_v[0]),
        .mem_read(mem_read_v[0]), .mem_write(mem_write_v[0]),
        .mem_addr(mem_addr_v[0]), .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]),
        .busy(busy_v[0]), .gnt_id(gnt_v[0])
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst_n(rst_n_v[1]),
        .req0(req0_v[1]), .we0(we0_v[1]), .addr0(addr0_v[1]), .wdata0(wdata0_v[1]),
        .ack0(ack0_v[1]), .rdata0(rdata0_v[1]),
        .req1(req1_v[1]), .we1(we1_v[1]), .addr1(addr1_v[1]), .wdata1(wdata1_v[1]),
        .ack1(ack1_v[1]), .rdata1(rdata1_v[1]),
        .mem_read(mem_read_v[1]), .mem_write(mem_write_v[1]),
        .mem_addr(mem_addr_v[1]), .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]),
        .busy(busy_v[1]), .gnt_id(gnt_v[1])
    );

    // 256x8 memories: synchronous write, registered read
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_write_v[d]) tmem[d][mem_addr_v[d]] <= mem_wdata_v[d];
            if (mem_read_v[d])  mem_rdata_v[d] <= tmem[d][mem_addr_v[d]];
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fixed(input int d);
        return d == 1;
    endfunction

    function automatic logic get_ack(input int d, input int p);
        return (p == 0) ? ack0_v[d] : ack1_v[d];
    endfunction

    function automatic logic [7:0] get_rdata(input int d, input int p);
        return (p == 0) ? rdata0_v[d] : rdata1_v[d];
    endfunction

    task automatic drive(input int d, input int p, input bit r, input bit w,
                         input logic [7:0] a, input logic [7:0] v);
        if (p == 0) begin
            req0_v[d] = r; we0_v[d] = w; addr0_v[d] = a; wdata0_v[d] = v;
        end else begin
            req1_v[d] = r; we1_v[d] = w; addr1_v[d] = a; wdata1_v[d] = v;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset 3 cycles with req0 asserted; everything must stay quiet.
    task automatic do_reset(input int d);
        rst_n_v[d] = 1'b0;
        drive(d, 0, 1'b1, 1'b0, 8'h00, 8'h00);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst mem_read", mem_read_v[d], 8'h0);
            chk("rst mem_write", mem_write_v[d], 8'h0);
            chk("rst ack0", ack0_v[d], 8'h0);
            chk("rst ack1", ack1_v[d], 8'h0);
            chk("rst rdata0", rdata0_v[d], 8'h00);
            chk("rst rdata1", rdata1_v[d], 8'h00);
            chk("rst busy", busy_v[d], 8'h0);
            chk("rst mem_addr", mem_addr_v[d], 8'h00);
            chk("rst mem_wdata", mem_wdata_v[d], 8'h00);
            chk("rst gnt_id", gnt_v[d], 8'h0);
            tick();
        end
        rst_n_v[d] = 1'b1;
        drive(d, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        rr_ptr[d] = 1'b0;
        exp_rd[d][0] = 8'h00;
        exp_rd[d][1] = 8'h00;
    endtask

    // One arbitration round: model decides service order, then every cycle
    // strobes, busy, acks, read data and grant are compared.
    task automatic xact(input int d, input bit r0, input bit r1,
                        input bit w0, input logic [7:0] a0, input logic [7:0] v0,
                        input bit w1, input logic [7:0] a1, input logic [7:0] v1,
                        input bit keep);
        int first, last;
        int due [2];
        bit wr [2];
        logic [7:0] ad [2];
        logic [7:0] dt [2];
        bit acked [2];
        bit e_rd, e_wr, e_busy, e_ack;
        wr[0] = w0; ad[0] = a0; dt[0] = v0;
        wr[1] = w1; ad[1] = a1; dt[1] = v1;
        due[0] = 0; due[1] = 0;
        if (r0 && r1) begin
            first = is_fixed(d) ? 0 : (rr_ptr[d] ? 1 : 0);
            if (!is_fixed(d)) rr_ptr[d] = !rr_ptr[d];
            due[first] = 3;
            due[1 - first] = 6;
            last = 6;
        end else begin
            first = r0 ? 0 : 1;
            due[first] = 3;
            last = 3;
        end
        if (r0) drive(d, 0, 1'b1, w0, a0, v0);
        if (r1) drive(d, 1, 1'b1, w1, a1, v1);
        for (int n = 1; n <= last; n++) begin
            @(negedge clk);
            e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (due[p] != 0 && n == due[p] - 1) begin
                    if (wr[p]) e_wr = 1'b1; else e_rd = 1'b1;
                end
                if (due[p] != 0 && (n == due[p] - 1 || n == due[p])) begin
                    e_busy = 1'b1;
                    chk("mem_addr", mem_addr_v[d], ad[p]);
                    if (wr[p]) chk("mem_wdata", mem_wdata_v[d], dt[p]);
                end
            end
            chk("mem_read", mem_read_v[d], {7'd0, e_rd});
            chk("mem_write", mem_write_v[d], {7'd0, e_wr});
            chk("busy", busy_v[d], {7'd0, e_busy});
            for (int p = 0; p < 2; p++) begin
                e_ack = (due[p] == n);
                acked[p] = e_ack;
                if (e_ack) begin
                    if (wr[p]) ref_mem[d][ad[p]] = dt[p];
                    else exp_rd[d][p] = ref_mem[d][ad[p]];
                    chk("gnt_id", gnt_v[d], 8'(p));
                end
                chk(p == 0 ? "ack0" : "ack1", get_ack(d, p), {7'd0, e_ack});
                chk(p == 0 ? "rdata0" : "rdata1", get_rdata(d, p), exp_rd[d][p]);
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                if (acked[p] && !keep) begin
                    if (p == 0) req0_v[d] = 1'b0; else req1_v[d] = 1'b0;
                end
            end
        end
    endtask

    // Reset lands in the ISSUE cycle of a write: no strobe, no ack, memory intact.
    task automatic reset_mid_write(input int d, input logic [7:0] a, input logic [7:0] v);
        drive(d, 0, 1'b1, 1'b1, a, v);
        tick();
        rst_n_v[d] = 1'b0;
        @(negedge clk);
        chk("midrst mem_write", mem_write_v[d], 8'h0);
        chk("midrst mem_read", mem_read_v[d], 8'h0);
        chk("midrst ack0", ack0_v[d], 8'h0);
        tick();
        rst_n_v[d] = 1'b1;
        drive(d, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        rr_ptr[d] = 1'b0;
        exp_rd[d][0] = 8'h00;
        exp_rd[d][1] = 8'h00;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("midrst idle ack0", ack0_v[d], 8'h0);
            chk("midrst idle busy", busy_v[d], 8'h0);
            chk("midrst idle mem_write", mem_write_v[d], 8'h0);
            tick();
        end
    endtask

    int d_r, mode;
    bit rw0, rw1;
    logic [7:0] ra0, ra1, rv0, rv1;
    logic [7:0] burst_addr [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};

    initial begin
        checks = 0;
        errors = 0;
        rst_n_v = '0; req0_v = '0; we0_v = '0; req1_v = '0; we1_v = '0;
        for (int d = 0; d < 2; d++) begin
            addr0_v[d] = '0; wdata0_v[d] = '0; addr1_v[d] = '0; wdata1_v[d] = '0;
            exp_rd[d][0] = '0; exp_rd[d][1] = '0; rr_ptr[d] = 1'b0;
        end
        tick();
        do_reset(0);
        do_reset(1);

        // single write then read on port 0
        xact(0, 1, 0, 1, 8'h10, 8'hA5, 0, 8'h00, 8'h00, 0);
        xact(0, 1, 0, 0, 8'h10, 8'h00, 0, 8'h00, 8'h00, 0);

        // round-robin ties: port 0 first, then port 1 first
        xact(0, 1, 1, 0, 8'h10, 8'h00, 0, 8'h10, 8'h00, 0);
        xact(0, 1, 1, 0, 8'h10, 8'h00, 0, 8'h11, 8'h00, 0);

        // fixed priority: write wins over simultaneous read of same address
        xact(1, 0, 1, 0, 8'h00, 8'h00, 1, 8'h21, 8'h3C, 0);
        xact(1, 1, 0, 0, 8'h21, 8'h00, 0, 8'h00, 8'h00, 0);
        xact(1, 1, 1, 1, 8'h20, 8'h11, 0, 8'h20, 8'h00, 0);
        xact(1, 1, 1, 0, 8'h20, 8'h00, 1, 8'h20, 8'h99, 0);

        // back-to-back reads with req1 held across address wrap
        for (int i = 0; i < 5; i++)
            xact(0, 1, 0, 1, burst_addr[i], 8'(i + 1), 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++)
            xact(0, 0, 1, 0, 8'h00, 8'h00, 0, burst_addr[i], 8'h00, i < 4);

        // reset during ISSUE of a write
        xact(0, 1, 0, 1, 8'h30, 8'h5C, 0, 8'h00, 8'h00, 0);
        reset_mid_write(0, 8'h30, 8'h77);
        xact(0, 0, 1, 0, 8'h00, 8'h00, 0, 8'h30, 8'h00, 0);
        xact(0, 1, 1, 0, 8'h30, 8'h00, 0, 8'h10, 8'h00, 0);

        // randomized rounds on both arbiters
        for (int it = 0; it < 160; it++) begin
            d_r  = it % 2;
            mode = $urandom_range(1, 3);
            rw0  = 1'($urandom_range(0, 1));
            rw1  = 1'($urandom_range(0, 1));
            ra0  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(252, 255));
            ra1  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(252, 255));
            rv0  = 8'($urandom_range(0, 255));
            rv1  = 8'($urandom_range(0, 255));
            xact(d_r, mode[0], mode[1], rw0, ra0, rv0, rw1, ra1, rv1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the 256x8 single-port data memory (synchronous write, registered 1-cycle read). Port 0 is the CPU MEM stage; port 1 is the program/data loader or debug path. The block serialises accesses, drives the memory's read/write strobes, address and write data, and returns read data with a one-cycle ack pulse per access.

Parameters:
ADDR_W, 8, memory address width (256 locations).
DATA_W, 8, data word width.
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins a simultaneous request.

Ports:
clk  input  1  system clock, all logic on posedge.
rst_n  input  1  synchronous active-low reset.
req0  input  1  port 0 access request, held until ack0.
we0  input  1  port 0: 1 = write, 0 = read.
addr0  input  ADDR_W  port 0 address.
wdata0  input  DATA_W  port 0 write data.
ack0  output  1  one-cycle completion pulse, port 0.
rdata0  output  DATA_W  port 0 read data, valid with ack0 of a read.
req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
mem_read  output  1  to memory read enable.
mem_write  output  1  to memory write enable.
mem_addr  output  ADDR_W  to memory address.
mem_wdata  output  DATA_W  to memory write data.
mem_rdata  input  DATA_W  from memory registered read output.
busy  output  1  high in any state other than IDLE.
gnt_id  output  1  port owning the current or last access.

Behaviour:
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. One access per 3 cycles.
- IDLE: if req0 or req1, select a winner, latch its we/addr/wdata into internal registers, set gnt_id, go to ISSUE. Otherwise stay.
- Winner: one requester wins alone. On a tie with FIXED_PRIO=1, port 0 wins. On a tie with FIXED_PRIO=0, the port named by the priority pointer wins, then the pointer moves to the other port. The pointer updates only on a tie-break.
- ISSUE: mem_write = latched we, mem_read = not latched we, both combinational from state, high for exactly this cycle. mem_addr/mem_wdata come from the latched registers and are stable from ISSUE through RESP. Go to RESP.
- RESP: ackN=1 for the granted port only, for one cycle. On a read, rdataN <= mem_rdata, registered so it is visible from the ack cycle onward. rdataN holds until that port's next read completes; writes never change rdataN. Go to IDLE.
- Requester rules: req, we, addr and wdata stay stable until ack. Changes before ack are undefined use. A req still high in the cycle after ack counts as a new request.
- Loser's req stays pending and is served in the next IDLE. No request is dropped. Worst-case wait is 3 cycles plus one access.
- Reset (rst_n=0 at a posedge): state=IDLE, ack0=ack1=0, rdata0=rdata1=0, gnt_id=0, latched addr/wdata/we=0, pointer = port 0.
- mem_read and mem_write are gated by rst_n, so no memory op occurs in any cycle where rst_n=0, even mid-ISSUE. An access interrupted by reset is abandoned with no ack.
- mem_addr=0, mem_wdata=0 out of reset. busy=0 in IDLE.
- Width rules: address and data pass through unmodified. No arithmetic besides the 1-bit pointer toggle.

Decomposition:
- Shared package dmem_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2), port id constants.
- One natural sub-module, rr_arb2: combinational 2-way winner select with a registered priority pointer and FIXED_PRIO override. The FSM and datapath latches stay in dmem_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req0=1 -> mem_read=mem_write=0, ack0=ack1=0, rdata0=rdata1=0, busy=0 throughout.
- Single write then read on port 0: write addr 8'h10 data 8'hA5, ack0 on 3rd cycle after req. Then read 8'h10 -> rdata0=8'hA5 with ack0, mem_read high exactly one cycle.
- Tie round-robin (FIXED_PRIO=0): req0 and req1 both reading after reset -> port 0 acked first, port 1 acked 3 cycles later. Repeat the tie -> port 1 first.
- Fixed priority (FIXED_PRIO=1): port 0 writes 8'h20=8'h11 while port 1 reads 8'h20 simultaneously -> port 0 first, then rdata1=8'h11. rdata0 is unchanged by the write.
- Back-to-back: port 1 holds req1 for 5 reads at addresses 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02 (pre-loaded 8'h01..8'h05) -> 5 ack1 pulses 3 cycles apart, data 8'h01..8'h05 in order.
- Reset mid-op: assert rst_n=0 during the ISSUE cycle of a write to 8'h30=8'h77 -> mem_write stays 0, no ack. Subsequent read of 8'h30 returns the prior value.
